// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Execute stage. RV32I ALU/branch/jump/LUI/AUIPC ops resolve
//               combinationally. RV32M MUL/DIV/REM run in an iterative unit
//               (shift-add multiply, restoring divide) that stalls the
//               pipeline through hold_flag_o while it works.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int XLEN             = 32,
  parameter bit MUL_SINGLE_CYCLE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wen_i,
  input  logic [XLEN-1:0] base_addr_i,
  input  logic [XLEN-1:0] addr_offset_i,
  input  logic            flush_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            jump_en_o,
  output logic            hold_flag_o,
  output logic            busy_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [SHW-1:0]  CNT_ONE  = SHW'(1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // ---------------------------------------------------------------- decode
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [SHW-1:0]  shamt;
  logic            is_m;
  logic            m_iter;
  logic            sgn1;
  logic            sgn2;
  logic            unused_inst;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign shamt  = op2_i[SHW-1:0];
  assign is_m   = (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  // Divides always iterate; multiplies iterate only in the multi-cycle build
  assign m_iter = is_m && (funct3[2] || !MUL_SINGLE_CYCLE);
  // op1 is signed for MULH, MULHSU, DIV, REM; op2 for MULH, DIV, REM.
  // MUL low half is sign-agnostic so it runs unsigned.
  assign sgn1   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sgn2   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  // rd comes in on rd_addr_i, so the instruction rd field is not needed
  assign unused_inst = ^inst_i[11:7];

  // ------------------------------------------------------------ base ALU
  logic [XLEN-1:0] add_res, sub_res, sll_res, srl_res, sra_res, alu_res;
  logic [XLEN-1:0] upimm, jsum;
  logic [31:0]     upimm32;
  logic            lt_s, lt_u, eq;

  assign add_res = op1_i + op2_i;
  assign sub_res = op1_i - op2_i;
  assign sll_res = op1_i << shamt;
  assign srl_res = op1_i >> shamt;
  assign sra_res = $signed(op1_i) >>> shamt;
  assign lt_s    = $signed(op1_i) < $signed(op2_i);
  assign lt_u    = op1_i < op2_i;
  assign eq      = op1_i == op2_i;
  assign jsum    = base_addr_i + addr_offset_i;
  assign upimm32 = {inst_i[31:12], 12'b0};

  generate
    if (XLEN > 32) begin : g_upimm_ext
      assign upimm = {{(XLEN-32){upimm32[31]}}, upimm32};
    end else begin : g_upimm_trunc
      assign upimm = upimm32[XLEN-1:0];
    end
  endgenerate

  // Combinational multiplier, only built for the single-cycle MUL option
  logic [XLEN-1:0] mul_comb;
  generate
    if (MUL_SINGLE_CYCLE) begin : g_mul_comb
      logic [2*XLEN-1:0] m1, m2, prod;
      assign m1       = {{XLEN{sgn1 & op1_i[XLEN-1]}}, op1_i};
      assign m2       = {{XLEN{sgn2 & op2_i[XLEN-1]}}, op2_i};
      assign prod     = m1 * m2;
      assign mul_comb = (funct3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin : g_mul_iter
      assign mul_comb = '0;
    end
  endgenerate

  // Shared ALU result; only register-register SUB uses inst[30] at funct3 000
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = ((opcode == OPC_OP) && inst_i[30]) ? sub_res : add_res;
      3'b001:  alu_res = sll_res;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      3'b100:  alu_res = op1_i ^ op2_i;
      3'b101:  alu_res = inst_i[30] ? sra_res : srl_res;
      3'b110:  alu_res = op1_i | op2_i;
      default: alu_res = op1_i & op2_i;
    endcase
  end

  // Base-op outputs; anything not recognised leaves everything at zero
  logic            base_wen;
  logic [XLEN-1:0] base_data;
  logic [XLEN-1:0] base_jaddr;
  logic            base_jen;

  always_comb begin
    base_wen   = 1'b0;
    base_data  = '0;
    base_jaddr = '0;
    base_jen   = 1'b0;
    case (opcode)
      OPC_IMM: begin
        base_wen  = 1'b1;
        base_data = alu_res;
      end
      OPC_OP: begin
        if ((funct7 == F7_BASE) ||
            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          base_wen  = 1'b1;
          base_data = alu_res;
        end else if ((funct7 == F7_MULDIV) && MUL_SINGLE_CYCLE && !funct3[2]) begin
          base_wen  = 1'b1;
          base_data = mul_comb;
        end
      end
      OPC_BR: begin
        if ((funct3 != 3'b010) && (funct3 != 3'b011)) begin
          base_jaddr = jsum;
          case (funct3)
            3'b000:  base_jen = eq;
            3'b001:  base_jen = !eq;
            3'b100:  base_jen = lt_s;
            3'b101:  base_jen = !lt_s;
            3'b110:  base_jen = lt_u;
            default: base_jen = !lt_u;
          endcase
        end
      end
      OPC_JAL: begin
        base_wen   = 1'b1;
        base_data  = add_res;
        base_jaddr = jsum;
        base_jen   = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          base_wen   = 1'b1;
          base_data  = add_res;
          base_jaddr = {jsum[XLEN-1:1], 1'b0};
          base_jen   = 1'b1;
        end
      end
      OPC_LUI: begin
        base_wen  = 1'b1;
        base_data = upimm;
      end
      OPC_AUIPC: begin
        base_wen  = 1'b1;
        base_data = inst_addr_i + upimm;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------- M unit state
  logic [1:0]        state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Operand conditioning, one iteration step and final sign fix-up
  logic              a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_val;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] step, prod_fix;
  logic [XLEN-1:0]   quo_raw, rem_raw, fix_res;

  always_comb begin
    a_neg   = sgn1 & op1_i[XLEN-1];
    b_neg   = sgn2 & op2_i[XLEN-1];
    a_mag   = a_neg ? -op1_i : op1_i;
    b_mag   = b_neg ? -op2_i : op2_i;
    div0    = (op2_i == '0);
    ovf     = sgn2 && (op1_i == INT_MIN) && (&op2_i);
    special = funct3[2] && (div0 || ovf);
    // funct3[1] set means REM/REMU, otherwise DIV/DIVU
    if (funct3[1]) special_val = div0 ? op1_i : '0;
    else           special_val = div0 ? '1 : op1_i;

    // Multiply: acc = {partial high, multiplier}; add on LSB then shift right
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Divide: acc = {remainder, dividend/quotient}; restoring shift-subtract
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, b_q};
    if (f3_q[2]) begin
      if (div_diff[XLEN]) step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod_fix = neg_q ? -step : step;
    quo_raw  = step[XLEN-1:0];
    rem_raw  = step[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:          fix_res = prod_fix[XLEN-1:0];
      3'b100, 3'b101:  fix_res = neg_q ? -quo_raw : quo_raw;
      3'b110, 3'b111:  fix_res = negr_q ? -rem_raw : rem_raw;
      default:         fix_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // State register: all M-unit flops, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic: start, iterate, finish; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (m_iter && !flush_i) begin
          f3_d   = funct3;
          rd_d   = rd_addr_i;
          neg_d  = a_neg ^ b_neg;
          negr_d = a_neg;
          acc_d  = {{XLEN{1'b0}}, a_mag};
          b_d    = b_mag;
          if (special) begin
            res_d   = special_val;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_LAST;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = step;
        if (cnt_q == '0) begin
          res_d   = fix_res;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Output logic: base ops when idle, stall while busy, write back when done
  always_comb begin
    rd_addr_o   = '0;
    rd_data_o   = '0;
    rd_wen_o    = 1'b0;
    jump_addr_o = '0;
    jump_en_o   = 1'b0;
    hold_flag_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m_iter) begin
          hold_flag_o = !flush_i;
        end else begin
          if (base_wen) begin
            rd_addr_o = rd_addr_i;
            rd_wen_o  = rd_wen_i;
            rd_data_o = base_data;
          end
          jump_addr_o = base_jaddr;
          jump_en_o   = base_jen;
        end
      end
      S_BUSY: hold_flag_o = !flush_i;
      S_DONE: begin
        if (!flush_i) begin
          rd_wen_o  = 1'b1;
          rd_addr_o = rd_q;
          rd_data_o = res_q;
        end
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Directed bench for ex_muldiv: table of combinational base-op
//               vectors plus hand-written multi-cycle M-unit sequences on a
//               32-bit iterative instance and a 64-bit single-cycle-MUL one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [31:0] NOP_UNK = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush_i, rd_wen_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i, base_addr_i, addr_offset_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, jump_addr_o;
  logic        rd_wen_o, jump_en_o, hold_flag_o, busy_o;

  logic [31:0] b_inst;
  logic [63:0] b_op1, b_op2, b_zero;
  logic [4:0]  b_rd_addr_o;
  logic [63:0] b_rd_data_o, b_jump_addr_o;
  logic        b_rd_wen_o, b_jump_en_o, b_hold_flag_o, b_busy_o;

  ex_muldiv #(.XLEN(32), .MUL_SINGLE_CYCLE(1'b0)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
    .base_addr_i(base_addr_i), .addr_offset_i(addr_offset_i), .flush_i(flush_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
    .jump_addr_o(jump_addr_o), .jump_en_o(jump_en_o),
    .hold_flag_o(hold_flag_o), .busy_o(busy_o)
  );

  ex_muldiv #(.XLEN(64), .MUL_SINGLE_CYCLE(1'b1)) dut64 (
    .clk(clk), .rst(rst), .inst_i(b_inst), .inst_addr_i(b_zero),
    .op1_i(b_op1), .op2_i(b_op2), .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
    .base_addr_i(b_zero), .addr_offset_i(b_zero), .flush_i(flush_i),
    .rd_addr_o(b_rd_addr_o), .rd_data_o(b_rd_data_o), .rd_wen_o(b_rd_wen_o),
    .jump_addr_o(b_jump_addr_o), .jump_en_o(b_jump_en_o),
    .hold_flag_o(b_hold_flag_o), .busy_o(b_busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc);
    return {f7, 10'b0, f3, 5'b0, opc};
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] data;
    logic        wen;
    logic [31:0] jaddr;
    logic        jen;
  } vec_t;

  vec_t vecs[$];

  // Run one iterative M op on the 32-bit instance and check result and timing
  task automatic run_m(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_cyc);
    int  n;
    int  holds;
    bit  seen;
    @(posedge clk); #1;
    inst_i = enc(7'h01, f3, OPC_OP); op1_i = a; op2_i = b; rd_addr_i = rd;
    n = 0; holds = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (rd_wen_o) seen = 1'b1;
      else if (hold_flag_o) holds++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_cyc));
    check({name, " hold cycles"}, 64'(holds), 64'(exp_cyc - 1));
    check({name, " rd_data"}, rd_data_o, exp);
    check({name, " rd_addr"}, rd_addr_o, rd);
    check({name, " hold in DONE"}, hold_flag_o, 1'b0);
    @(posedge clk); #1;
    inst_i = NOP_UNK; rd_addr_i = 5'd5;
    @(negedge clk);
    check({name, " busy after"}, busy_o, 1'b0);
  endtask

  // Abort a MUL in its 10th BUSY cycle by flush_i or rst
  task automatic abort_test(input string name, input bit use_rst);
    int wens;
    @(posedge clk); #1;
    inst_i = enc(7'h01, 3'b000, OPC_OP); op1_i = 32'd9; op2_i = 32'd9;
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else flush_i = 1'b1;
    @(negedge clk);
    check({name, " wen in abort cycle"}, rd_wen_o, 1'b0);
    check({name, " busy in abort cycle"}, busy_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; flush_i = 1'b0; inst_i = NOP_UNK;
    @(negedge clk);
    check({name, " busy after abort"}, busy_o, 1'b0);
    wens = 0;
    repeat (40) begin
      @(negedge clk);
      if (rd_wen_o) wens++;
    end
    check({name, " writes after abort"}, 64'(wens), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    rst = 1'b1; flush_i = 1'b0; rd_wen_i = 1'b1; rd_addr_i = 5'd5;
    inst_i = NOP_UNK; inst_addr_i = '0; op1_i = '0; op2_i = '0;
    base_addr_i = '0; addr_offset_i = '0;
    b_inst = NOP_UNK; b_op1 = '0; b_op2 = '0; b_zero = '0;

    // inst, op1, op2, pc, base, off, data, wen, jaddr, jen
    vecs.push_back('{enc(7'h00, 3'b000, OPC_IMM), 32'd5, 32'hFFFF_FFFD, 32'h0, 32'h0, 32'h0, 32'd2, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b100, OPC_IMM), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 32'h0, 32'hFF00_FF00, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b111, OPC_IMM), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 32'h0, 32'h00F0_00F0, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h20, 3'b000, OPC_OP), 32'd5, 32'd7, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b001, OPC_OP), 32'd1, 32'h3F, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h20, 3'b101, OPC_OP), 32'h8000_0000, 32'h24, 32'h0, 32'h0, 32'h0, 32'hF800_0000, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b101, OPC_IMM), 32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'h0, 32'h0800_0000, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b010, OPC_OP), 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'd0, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b011, OPC_OP), 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'd1, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b000, OPC_BR), 32'd7, 32'd7, 32'h0, 32'h100, 32'h20, 32'd0, 1'b0, 32'h120, 1'b1});
    vecs.push_back('{enc(7'h00, 3'b001, OPC_BR), 32'd7, 32'd7, 32'h0, 32'h100, 32'h20, 32'd0, 1'b0, 32'h120, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b100, OPC_BR), 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h100, 32'h20, 32'd0, 1'b0, 32'h120, 1'b1});
    vecs.push_back('{enc(7'h00, 3'b110, OPC_BR), 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h100, 32'h20, 32'd0, 1'b0, 32'h120, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b111, OPC_BR), 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h100, 32'h20, 32'd0, 1'b0, 32'h120, 1'b1});
    vecs.push_back('{enc(7'h00, 3'b000, OPC_JAL), 32'h200, 32'd4, 32'h0, 32'h200, 32'h40, 32'h204, 1'b1, 32'h240, 1'b1});
    vecs.push_back('{enc(7'h00, 3'b000, OPC_JALR), 32'h300, 32'd4, 32'h0, 32'h301, 32'h4, 32'h304, 1'b1, 32'h304, 1'b1});
    vecs.push_back('{32'h1234_5037, 32'd0, 32'd0, 32'h0, 32'h0, 32'h0, 32'h1234_5000, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{32'h0000_1017, 32'd0, 32'd0, 32'h100, 32'h0, 32'h0, 32'h0000_1100, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{32'h0000_007F, 32'd5, 32'd5, 32'h0, 32'h100, 32'h20, 32'd0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h00, 3'b010, OPC_BR), 32'd7, 32'd7, 32'h0, 32'h100, 32'h20, 32'd0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{enc(7'h10, 3'b000, OPC_OP), 32'd5, 32'd5, 32'h0, 32'h100, 32'h20, 32'd0, 1'b0, 32'h0, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy_o, 1'b0);
    check("reset hold", hold_flag_o, 1'b0);
    check("reset rd_wen", rd_wen_o, 1'b0);
    check("reset rd_data", rd_data_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Combinational base ops
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      inst_i = vecs[i].inst; op1_i = vecs[i].op1; op2_i = vecs[i].op2;
      inst_addr_i = vecs[i].pc; base_addr_i = vecs[i].base; addr_offset_i = vecs[i].off;
      @(negedge clk);
      check($sformatf("vec%0d rd_data", i), rd_data_o, vecs[i].data);
      check($sformatf("vec%0d rd_wen", i), rd_wen_o, vecs[i].wen);
      check($sformatf("vec%0d rd_addr", i), rd_addr_o, vecs[i].wen ? 5'd5 : 5'd0);
      check($sformatf("vec%0d jump_addr", i), jump_addr_o, vecs[i].jaddr);
      check($sformatf("vec%0d jump_en", i), jump_en_o, vecs[i].jen);
      check($sformatf("vec%0d hold", i), hold_flag_o, 1'b0);
    end
    @(posedge clk); #1;
    inst_i = NOP_UNK; base_addr_i = '0; addr_offset_i = '0; inst_addr_i = '0;

    // Iterative M ops
    run_m("MUL",    3'b000, 32'hFFFF_FFFF, 32'd3, 5'd7, 32'hFFFF_FFFD, 34);
    run_m("MULHU",  3'b011, 32'hFFFF_FFFF, 32'd3, 5'd7, 32'h0000_0002, 34);
    run_m("MULH",   3'b001, 32'hFFFF_FFFF, 32'd3, 5'd7, 32'hFFFF_FFFF, 34);
    run_m("MULHSU", 3'b010, 32'd3, 32'hFFFF_FFFF, 5'd9, 32'h0000_0002, 34);
    run_m("MUL x0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42, 34);
    run_m("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 34);
    run_m("REM",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 34);
    run_m("REMU",   3'b111, 32'd100, 32'd7, 5'd3, 32'd2, 34);
    run_m("DIVU/0", 3'b101, 32'd7, 32'd0, 5'd4, 32'hFFFF_FFFF, 2);
    run_m("REMU/0", 3'b111, 32'd7, 32'd0, 5'd4, 32'd7, 2);
    run_m("REM/0",  3'b110, 32'hFFFF_FFFB, 32'd0, 5'd4, 32'hFFFF_FFFB, 2);
    run_m("DIVovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 2);
    run_m("REMovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0, 2);

    // Abort paths
    abort_test("flush", 1'b0);
    abort_test("rst", 1'b1);

    // flush_i beats a simultaneous start
    @(posedge clk); #1;
    inst_i = enc(7'h01, 3'b100, OPC_OP); op1_i = 32'd9; op2_i = 32'd3; flush_i = 1'b1;
    @(negedge clk);
    check("flush+start hold", hold_flag_o, 1'b0);
    check("flush+start wen", rd_wen_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0; inst_i = NOP_UNK;
    @(negedge clk);
    check("flush+start busy", busy_o, 1'b0);

    // 64-bit instance with single-cycle multiply
    @(posedge clk); #1;
    b_inst = enc(7'h01, 3'b011, OPC_OP); b_op1 = 64'h1 << 40; b_op2 = 64'h1 << 30;
    @(negedge clk);
    check("X64 MULHU data", b_rd_data_o, 64'h40);
    check("X64 MULHU wen", b_rd_wen_o, 1'b1);
    check("X64 MULHU hold", b_hold_flag_o, 1'b0);
    check("X64 MULHU busy", b_busy_o, 1'b0);
    @(posedge clk); #1;
    b_inst = enc(7'h01, 3'b000, OPC_OP);
    @(negedge clk);
    check("X64 MUL data", b_rd_data_o, 64'h0);
    @(posedge clk); #1;
    b_inst = enc(7'h01, 3'b101, OPC_OP); b_op1 = 64'd100; b_op2 = 64'd7; rd_addr_i = 5'd11;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (b_rd_wen_o) seen = 1'b1;
    end
    check("X64 DIVU latency", 64'(n), 64'd66);
    check("X64 DIVU data", b_rd_data_o, 64'd14);
    check("X64 DIVU rd_addr", b_rd_addr_o, 5'd11);
    @(posedge clk); #1;
    b_inst = NOP_UNK;

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
